// File: rtl/change_return_sequencer.sv
// Change return sequencer: pays an owed amount greedily, largest coin first,
// one coin per valid/ready handshake, while tracking per-coin stock.
module change_return_sequencer #(
  parameter int NUM_COINS = 3,
  parameter int COIN_VAL0 = 100,
  parameter int COIN_VAL1 = 500,
  parameter int COIN_VAL2 = 1000,
  parameter int STOCK_W   = 8
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         i_start,
  input  logic [31:0]                  i_amount,
  input  logic                         i_stock_load,
  input  logic [NUM_COINS*STOCK_W-1:0] i_stock_data,
  input  logic                         i_coin_ready,
  output logic                         o_coin_valid,
  output logic [NUM_COINS-1:0]         o_return_coin,
  output logic [31:0]                  o_remaining,
  output logic [NUM_COINS*STOCK_W-1:0] o_stock,
  output logic                         o_busy,
  output logic                         o_done,
  output logic                         o_short
);

  localparam int IDX_W = (NUM_COINS > 1) ? $clog2(NUM_COINS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SELECT,
    DISPENSE,
    DONE
  } state_t;

  state_t                       state;
  state_t                       state_nxt;
  logic [31:0]                  remaining;
  logic [NUM_COINS*STOCK_W-1:0] stock;
  logic [NUM_COINS-1:0]         coin_sel;
  logic [IDX_W-1:0]             coin_idx;
  logic                         short_flag;
  logic                         pick_found;
  logic [IDX_W-1:0]             pick_idx;

  function automatic logic [31:0] coin_val(input int k);
    case (k)
      0:       return 32'(COIN_VAL0);
      1:       return 32'(COIN_VAL1);
      default: return 32'(COIN_VAL2);
    endcase
  endfunction

  // Ascending scan, so the last match is the largest affordable coin in stock.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = 0; k < NUM_COINS; k++) begin
      if ((coin_val(k) <= remaining) && (stock[k*STOCK_W +: STOCK_W] != '0)) begin
        pick_found = 1'b1;
        pick_idx   = IDX_W'(k);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    o_coin_valid = 1'b0;
    o_busy       = 1'b1;
    o_done       = 1'b0;
    case (state)
      IDLE: begin
        o_busy = 1'b0;
        if (i_start) begin
          state_nxt = (i_amount == 32'd0) ? DONE : SELECT;
        end
      end
      SELECT: begin
        state_nxt = pick_found ? DISPENSE : DONE;
      end
      DISPENSE: begin
        o_coin_valid = 1'b1;
        if (i_coin_ready) begin
          state_nxt = SELECT;
        end
      end
      DONE: begin
        o_done    = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // A start in IDLE wins over a stock load in the same cycle; the load is lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      remaining  <= '0;
      stock      <= '0;
      coin_sel   <= '0;
      coin_idx   <= '0;
      short_flag <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_start) begin
            remaining  <= i_amount;
            short_flag <= 1'b0;
          end else if (i_stock_load) begin
            stock <= i_stock_data;
          end
        end
        SELECT: begin
          if (pick_found) begin
            coin_sel <= NUM_COINS'(1) << pick_idx;
            coin_idx <= pick_idx;
          end else begin
            short_flag <= (remaining != 32'd0);
          end
        end
        DISPENSE: begin
          if (i_coin_ready) begin
            remaining <= remaining - coin_val(int'(coin_idx));
            stock[int'(coin_idx)*STOCK_W +: STOCK_W] <=
              stock[int'(coin_idx)*STOCK_W +: STOCK_W] - STOCK_W'(1);
            coin_sel <= '0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign o_return_coin = coin_sel;
  assign o_remaining   = remaining;
  assign o_stock       = stock;
  assign o_short       = short_flag;

endmodule
